// File: rtl/mac_frame_accumulator_pkg.sv
// Shared definitions for the multiply-add datapath (package task_5).
// Holds the multiply-add result width and the frame-accumulator sizing:
// frame length, overflow-free sum width and sample-count width.
package task_5;

    // Width of the registered A*B+C result feeding the accumulator.
    localparam int SIZE_DATA_OUT = 16;

    // Default number of samples summed per frame (must be >= 2).
    localparam int FRAME_LEN = 16;

    // Sum width: IN_W + log2(FRAME_LEN) bits can never wrap.
    localparam int ACC_W = SIZE_DATA_OUT + $clog2(FRAME_LEN);

    // Sample-count width: must be able to hold FRAME_LEN itself.
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    typedef logic [ACC_W-1:0] acc_t;
    typedef logic [CNT_W-1:0] cnt_t;

endpackage : task_5

// File: rtl/mac_frame_accumulator.sv
// mac_frame_accumulator
//
// Sums frames of FRAME_LEN unsigned samples from the multiply-add stage and
// presents each full-precision sum, with its sample count, through a
// one-entry output register. A flush pulse closes a partial frame early.
//
// Optional build macro MAC_FRAME_PEAK_EN adds out_peak, the largest sample
// accepted in the frame, loaded and held alongside out_sum.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready. A producer holding valid keeps its data stable until
// that edge; ready may depend combinationally on the consumer's own state
// and on out_ready, but never on in_valid.
//
// Control state is a single flush_pend flag:
//   ACCUM (flush_pend=0): normal accumulation.
//   PEND  (flush_pend=1): a flush arrived while the output slot was busy;
//                         input is blocked and the close runs as soon as the
//                         slot is free.
module mac_frame_accumulator #(
    parameter int FRAME_LEN = task_5::FRAME_LEN,
    parameter int IN_W      = task_5::SIZE_DATA_OUT,
    parameter int ACC_W     = IN_W + $clog2(FRAME_LEN),
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_valid,
    input  logic             out_ready
`ifdef MAC_FRAME_PEAK_EN
    ,
    output logic [IN_W-1:0]  out_peak
`endif
);

    // Count value at which the next accepted sample completes the frame.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    // Registered state.
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             flush_pend;

    // Combinational helpers.
    logic             slot_free;
    logic             accept;
    logic             nonempty;
    logic             close;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] cnt_sum;

    // Next-state values.
    logic [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             flush_pend_nxt;
    logic [ACC_W-1:0] out_sum_nxt;
    logic [CNT_W-1:0] out_count_nxt;
    logic             out_valid_nxt;

`ifdef MAC_FRAME_PEAK_EN
    logic [IN_W-1:0]  peak;
    logic [IN_W-1:0]  peak_upd;
    logic [IN_W-1:0]  peak_nxt;
    logic [IN_W-1:0]  out_peak_nxt;
`endif

    // Handshake decode, frame-close decision and next-state computation.
    always_comb begin
        slot_free      = 1'b0;
        in_ready       = 1'b0;
        accept         = 1'b0;
        nonempty       = 1'b0;
        close          = 1'b0;
        acc_sum        = acc;
        cnt_sum        = cnt;
        acc_nxt        = acc;
        cnt_nxt        = cnt;
        flush_pend_nxt = flush_pend;
        out_sum_nxt    = out_sum;
        out_count_nxt  = out_count;
        out_valid_nxt  = out_valid;

        // The slot can take a new frame if it is empty or draining now.
        slot_free = !out_valid || out_ready;

        // While stalled, keep accumulating up to (but not including) the
        // sample that would complete the frame; a pending flush blocks input
        // so the partial frame it closed is not extended.
        in_ready = slot_free || ((cnt < LAST_CNT) && !flush_pend);
        accept   = in_valid && in_ready;

        if (accept) begin
            acc_sum = acc + ACC_W'(in_data);
            cnt_sum = cnt + CNT_W'(1);
        end

        // A frame is non-empty if it already holds samples or gains one now.
        nonempty = (cnt != '0) || accept;

        // A full-frame accept implies slot_free (in_ready needs it when
        // cnt==LAST_CNT), so both close causes always find the slot free and
        // a flush on the final sample still gives exactly one close.
        close = (accept && (cnt == LAST_CNT))
             || ((flush || flush_pend) && nonempty && slot_free);

        // The slot empties after a handshake unless refilled below.
        if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
        end

        if (close) begin
            out_sum_nxt    = acc_sum;
            out_count_nxt  = cnt_sum;
            out_valid_nxt  = 1'b1;
            acc_nxt        = '0;
            cnt_nxt        = '0;
            flush_pend_nxt = 1'b0;
        end else begin
            acc_nxt = acc_sum;
            cnt_nxt = cnt_sum;
            // Remember a flush of a non-empty frame that could not close yet;
            // an empty-frame flush is dropped.
            if (flush && nonempty && !slot_free) begin
                flush_pend_nxt = 1'b1;
            end
        end
    end

    // Accumulator, counter, flush flag and output slot registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc        <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
            out_sum    <= '0;
            out_count  <= '0;
            out_valid  <= 1'b0;
        end else begin
            acc        <= acc_nxt;
            cnt        <= cnt_nxt;
            flush_pend <= flush_pend_nxt;
            out_sum    <= out_sum_nxt;
            out_count  <= out_count_nxt;
            out_valid  <= out_valid_nxt;
        end
    end

`ifdef MAC_FRAME_PEAK_EN
    // Running maximum of the frame, restarted on every close.
    always_comb begin
        peak_upd     = peak;
        peak_nxt     = peak;
        out_peak_nxt = out_peak;
        if (accept && (in_data > peak)) begin
            peak_upd = in_data;
        end
        if (close) begin
            out_peak_nxt = peak_upd;
            peak_nxt     = '0;
        end else begin
            peak_nxt = peak_upd;
        end
    end

    // Peak tracking register and its output copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak     <= '0;
            out_peak <= '0;
        end else begin
            peak     <= peak_nxt;
            out_peak <= out_peak_nxt;
        end
    end
`endif

endmodule : mac_frame_accumulator

// File: tb/tb_mac_frame_accumulator.sv
// Directed testbench for mac_frame_accumulator.
// u_dut4 runs with FRAME_LEN=4 for the functional scenarios; u_dut16 runs
// with the default FRAME_LEN=16 for the full-scale maximum-value frame.
// Build with MAC_FRAME_PEAK_EN defined to include the peak scenario.
module tb_mac_frame_accumulator;

    localparam int IN_W     = 16;
    localparam int A_W4     = IN_W + 2;
    localparam int C_W4     = 3;
    localparam int A_W16    = IN_W + 4;
    localparam int C_W16    = 5;

    // Clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // FRAME_LEN=4 instance signals
    logic [IN_W-1:0]  in_data4 = '0;
    logic             in_valid4 = 1'b0;
    logic             in_ready4;
    logic             flush4 = 1'b0;
    logic [A_W4-1:0]  out_sum4;
    logic [C_W4-1:0]  out_count4;
    logic             out_valid4;
    logic             out_ready4 = 1'b1;

    // FRAME_LEN=16 instance signals
    logic [IN_W-1:0]  in_data16 = '0;
    logic             in_valid16 = 1'b0;
    logic             in_ready16;
    logic             flush16 = 1'b0;
    logic [A_W16-1:0] out_sum16;
    logic [C_W16-1:0] out_count16;
    logic             out_valid16;
    logic             out_ready16 = 1'b1;

`ifdef MAC_FRAME_PEAK_EN
    logic [IN_W-1:0]  out_peak4;
    logic [IN_W-1:0]  out_peak16;
`endif

    int checks = 0;
    int errors = 0;

    mac_frame_accumulator #(.FRAME_LEN(4)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .flush     (flush4),
        .out_sum   (out_sum4),
        .out_count (out_count4),
        .out_valid (out_valid4),
        .out_ready (out_ready4)
`ifdef MAC_FRAME_PEAK_EN
        ,
        .out_peak  (out_peak4)
`endif
    );

    mac_frame_accumulator u_dut16 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data16),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .flush     (flush16),
        .out_sum   (out_sum16),
        .out_count (out_count16),
        .out_valid (out_valid16),
        .out_ready (out_ready16)
`ifdef MAC_FRAME_PEAK_EN
        ,
        .out_peak  (out_peak16)
`endif
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one sample on u_dut4 for one edge, then drop valid.
    task automatic send4(input logic [IN_W-1:0] d);
        in_data4  = d;
        in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid4); end
        checks++; if (out_sum4 !== '0) begin errors++; $display("FAIL reset_sum: got %0d expected 0", out_sum4); end
        checks++; if (out_count4 !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", out_count4); end
        checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready4); end
        #2;
        reset = 1'b0;
        step();
        checks++; if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin errors++; $display("FAIL reset_dut16: got valid=%0b ready=%0b expected valid=0 ready=1", out_valid16, in_ready16); end
    endtask

    task automatic test_frame_close();
        out_ready4 = 1'b1;
        send4(16'd100);
        send4(16'd200);
        send4(16'd300);
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL close_early_valid: got %0b expected 0", out_valid4); end
        send4(16'd400);
        checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL close_valid: got %0b expected 1", out_valid4); end
        checks++; if (out_sum4 !== 18'd1000) begin errors++; $display("FAIL close_sum: got %0d expected 1000", out_sum4); end
        checks++; if (out_count4 !== 3'd4) begin errors++; $display("FAIL close_count: got %0d expected 4", out_count4); end
        step();
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL close_drop: got %0b expected 0", out_valid4); end
        send4(16'd1);
        send4(16'd2);
        send4(16'd3);
        send4(16'd4);
        checks++; if (out_valid4 !== 1'b1 || out_sum4 !== 18'd10) begin errors++; $display("FAIL close_next_frame: got valid=%0b sum=%0d expected valid=1 sum=10", out_valid4, out_sum4); end
        step();
    endtask

    task automatic test_max_values();
        out_ready16 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data16  = 16'hFFFF;
            in_valid16 = 1'b1;
            step();
        end
        in_valid16 = 1'b0;
        checks++; if (out_valid16 !== 1'b1) begin errors++; $display("FAIL max_valid: got %0b expected 1", out_valid16); end
        checks++; if (out_sum16 !== 20'hFFFF0) begin errors++; $display("FAIL max_sum: got %0h expected ffff0", out_sum16); end
        checks++; if (out_count16 !== 5'd16) begin errors++; $display("FAIL max_count: got %0d expected 16", out_count16); end
        step();
        checks++; if (out_valid16 !== 1'b0) begin errors++; $display("FAIL max_drop: got %0b expected 0", out_valid16); end
    endtask

    task automatic test_stall();
        out_ready4 = 1'b0;
        send4(16'd10);
        send4(16'd20);
        send4(16'd30);
        send4(16'd40);
        checks++; if (out_valid4 !== 1'b1 || out_sum4 !== 18'd100) begin errors++; $display("FAIL stall_first_frame: got valid=%0b sum=%0d expected valid=1 sum=100", out_valid4, out_sum4); end
        for (int i = 1; i <= 3; i++) begin
            checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL stall_in_ready_%0d: got %0b expected 1", i, in_ready4); end
            send4(16'(i));
        end
        checks++; if (in_ready4 !== 1'b0) begin errors++; $display("FAIL stall_block_4th: got %0b expected 0", in_ready4); end
        in_data4  = 16'd4;
        in_valid4 = 1'b1;
        step();
        checks++; if (out_valid4 !== 1'b1 || out_sum4 !== 18'd100 || out_count4 !== 3'd4) begin errors++; $display("FAIL stall_hold: got valid=%0b sum=%0d count=%0d expected 1/100/4", out_valid4, out_sum4, out_count4); end
        out_ready4 = 1'b1;
        #1;
        checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %0b expected 1", in_ready4); end
        step();
        in_valid4 = 1'b0;
        checks++; if (out_valid4 !== 1'b1 || out_sum4 !== 18'd10 || out_count4 !== 3'd4) begin errors++; $display("FAIL stall_next_load: got valid=%0b sum=%0d count=%0d expected 1/10/4", out_valid4, out_sum4, out_count4); end
        step();
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL stall_drain: got %0b expected 0", out_valid4); end
    endtask

    task automatic test_flush();
        out_ready4 = 1'b1;
        send4(16'd5);
        send4(16'd7);
        flush4 = 1'b1;
        step();
        flush4 = 1'b0;
        checks++; if (out_valid4 !== 1'b1 || out_sum4 !== 18'd12 || out_count4 !== 3'd2) begin errors++; $display("FAIL flush_partial: got valid=%0b sum=%0d count=%0d expected 1/12/2", out_valid4, out_sum4, out_count4); end
        step();
        flush4 = 1'b1;
        step();
        flush4 = 1'b0;
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL flush_empty: got %0b expected 0", out_valid4); end
        step();
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL flush_empty_late: got %0b expected 0", out_valid4); end
        in_data4  = 16'd9;
        in_valid4 = 1'b1;
        flush4    = 1'b1;
        step();
        in_valid4 = 1'b0;
        flush4    = 1'b0;
        checks++; if (out_valid4 !== 1'b1 || out_sum4 !== 18'd9 || out_count4 !== 3'd1) begin errors++; $display("FAIL flush_same_cycle: got valid=%0b sum=%0d count=%0d expected 1/9/1", out_valid4, out_sum4, out_count4); end
        step();
        send4(16'd1);
        send4(16'd1);
        send4(16'd1);
        in_data4  = 16'd1;
        in_valid4 = 1'b1;
        flush4    = 1'b1;
        step();
        in_valid4 = 1'b0;
        flush4    = 1'b0;
        checks++; if (out_valid4 !== 1'b1 || out_sum4 !== 18'd4 || out_count4 !== 3'd4) begin errors++; $display("FAIL flush_on_last: got valid=%0b sum=%0d count=%0d expected 1/4/4", out_valid4, out_sum4, out_count4); end
        step();
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL flush_single_close: got %0b expected 0", out_valid4); end
    endtask

    task automatic test_flush_stalled();
        out_ready4 = 1'b0;
        for (int i = 0; i < 4; i++) send4(16'd50);
        send4(16'd6);
        send4(16'd8);
        flush4 = 1'b1;
        step();
        flush4 = 1'b0;
        checks++; if (in_ready4 !== 1'b0) begin errors++; $display("FAIL pend_in_ready: got %0b expected 0", in_ready4); end
        in_data4  = 16'd99;
        in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        checks++; if (out_valid4 !== 1'b1 || out_sum4 !== 18'd200 || in_ready4 !== 1'b0) begin errors++; $display("FAIL pend_hold: got valid=%0b sum=%0d ready=%0b expected 1/200/0", out_valid4, out_sum4, in_ready4); end
        out_ready4 = 1'b1;
        step();
        checks++; if (out_valid4 !== 1'b1 || out_sum4 !== 18'd14 || out_count4 !== 3'd2) begin errors++; $display("FAIL pend_emit: got valid=%0b sum=%0d count=%0d expected 1/14/2", out_valid4, out_sum4, out_count4); end
        step();
        checks++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin errors++; $display("FAIL pend_clear: got valid=%0b ready=%0b expected 0/1", out_valid4, in_ready4); end
    endtask

    task automatic test_reset_mid();
        out_ready4 = 1'b0;
        for (int i = 0; i < 4; i++) send4(16'd1);
        send4(16'd5);
        send4(16'd5);
        #3;
        reset = 1'b1;
        #1;
        checks++; if (out_valid4 !== 1'b0 || out_sum4 !== '0 || out_count4 !== '0) begin errors++; $display("FAIL async_reset: got valid=%0b sum=%0d count=%0d expected 0/0/0", out_valid4, out_sum4, out_count4); end
        checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL async_reset_ready: got %0b expected 1", in_ready4); end
        #2;
        reset = 1'b0;
        out_ready4 = 1'b1;
        step();
        for (int i = 0; i < 4; i++) send4(16'd7);
        checks++; if (out_valid4 !== 1'b1 || out_sum4 !== 18'd28 || out_count4 !== 3'd4) begin errors++; $display("FAIL post_reset_frame: got valid=%0b sum=%0d count=%0d expected 1/28/4", out_valid4, out_sum4, out_count4); end
        step();
    endtask

`ifdef MAC_FRAME_PEAK_EN
    task automatic test_peak();
        out_ready4 = 1'b1;
        send4(16'd3);
        send4(16'd900);
        send4(16'd12);
        send4(16'd40);
        checks++; if (out_peak4 !== 16'd900 || out_sum4 !== 18'd955) begin errors++; $display("FAIL peak_frame: got peak=%0d sum=%0d expected 900/955", out_peak4, out_sum4); end
        step();
        send4(16'd1);
        send4(16'd2);
        send4(16'd3);
        send4(16'd4);
        checks++; if (out_peak4 !== 16'd4) begin errors++; $display("FAIL peak_restart: got %0d expected 4", out_peak4); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_frame_close();
        test_max_values();
        test_stall();
        test_flush();
        test_flush_stalled();
        test_reset_mid();
`ifdef MAC_FRAME_PEAK_EN
        test_peak();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mac_frame_accumulator
